// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back / write-allocate cache controller with a
// single-beat-per-word backing-memory handshake.
module dm_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int WORD_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LA_W   = ADDR_W - 2;
    localparam int TAG_W  = LA_W - WORD_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                op_wr_q, op_wr_d;
    logic [WORD_W-1:0]   beat_q, beat_d;
    logic                err_q, err_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;

    logic [DATA_W-1:0]   data_q [LINES][WORDS];
    logic [TAG_W-1:0]    tag_q  [LINES];

    logic                dw_en;
    logic [WORD_W-1:0]   dw_word;
    logic [DATA_W-1:0]   dw_data;
    logic                tag_we;

    logic [WORD_W-1:0]   req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                last_beat;

    assign req_word  = addr_q[WORD_W-1:0];
    assign req_idx   = addr_q[WORD_W +: IDX_W];
    assign req_tag   = addr_q[LA_W-1 -: TAG_W];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign last_beat = (beat_q == WORD_W'(WORDS - 1));
    assign err       = err_q;

    // Next-state, array write controls and all combinational outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        beat_d    = beat_q;
        err_d     = 1'b0;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        dw_en     = 1'b0;
        dw_word   = req_word;
        dw_data   = wdata_q;
        tag_we    = 1'b0;
        Done      = 1'b0;
        CacheHit  = 1'b0;
        DataOut   = {DATA_W{1'b0}};
        Stall     = (state_q != IDLE);
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        case (state_q)
            IDLE: begin
                if ((Rd ^ Wr) && (Addr[1:0] == 2'b00)) begin
                    addr_d  = Addr[ADDR_W-1:2];
                    wdata_d = DataIn;
                    op_wr_d = Wr;
                    beat_d  = {WORD_W{1'b0}};
                    state_d = COMPARE;
                end else if (Rd || Wr) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                beat_d = {WORD_W{1'b0}};
                if (hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    if (op_wr_q) begin
                        dw_en            = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        DataOut = data_q[req_idx][req_word];
                    end
                    state_d = IDLE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                // Victim address is rebuilt from the stored tag, not the request.
                mem_wr    = 1'b1;
                mem_addr  = {tag_q[req_idx], req_idx, beat_q, 2'b00};
                mem_wdata = data_q[req_idx][beat_q];
                if (mem_ack) begin
                    beat_d = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        state_d = FILL;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else begin
                    state_d = WRITEBACK;
                end
            end
            FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {req_tag, req_idx, beat_q, 2'b00};
                if (mem_ack) begin
                    dw_en   = 1'b1;
                    dw_word = beat_q;
                    dw_data = mem_rdata;
                    beat_d  = beat_q + WORD_W'(1);
                    if (last_beat) begin
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        tag_we           = 1'b1;
                        state_d          = FINISH;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            FINISH: begin
                Done = 1'b1;
                if (op_wr_q) begin
                    dw_en            = 1'b1;
                    dirty_d[req_idx] = 1'b1;
                end else begin
                    DataOut = data_q[req_idx][req_word];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and per-line valid/dirty bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= {LA_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            op_wr_q <= 1'b0;
            beat_q  <= {WORD_W{1'b0}};
            err_q   <= 1'b0;
            valid_q <= {LINES{1'b0}};
            dirty_q <= {LINES{1'b0}};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag storage; contents are qualified by valid, so no reset.
    always_ff @(posedge clk) begin
        if (dw_en) begin
            data_q[req_idx][dw_word] <= dw_data;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter LINES, default 16, number of cache lines; must be a power of two, at least 2.
REQ-004 SHALL have parameter WORDS, default 4, words per line; must be a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port Addr, input, ADDR_W, byte address of the CPU request.
REQ-008 SHALL have port DataIn, input, DATA_W, CPU write data.
REQ-009 SHALL have ports Rd and Wr, inputs, 1 each, CPU read and write strobes.
REQ-010 SHALL have port DataOut, output, DATA_W, read data; valid only while Done=1.
REQ-011 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port Stall, output, 1, controller busy.
REQ-013 SHALL have port CacheHit, output, 1, qualifies Done: 1 means the access hit.
REQ-014 SHALL have port err, output, 1, one-cycle illegal-request pulse.
REQ-015 SHALL have ports mem_addr (output, ADDR_W, word-aligned), mem_wdata (output, DATA_W), mem_rd and mem_wr (outputs, 1), mem_rdata (input, DATA_W) and mem_ack (input, 1), forming the backing-memory beat handshake.

Function
REQ-016 SHALL decompose Addr as: byte offset [1:0]; word = next log2(WORDS) bits; index = next log2(LINES) bits; tag = remaining bits.
REQ-017 SHALL hold, per line, a valid bit, a dirty bit, a tag and WORDS data words; the cache is write-back and write-allocate.
REQ-018 SHALL use the FSM states IDLE, COMPARE, WRITEBACK, FILL and FINISH; Stall SHALL be 1 in every state except IDLE.
REQ-019 SHALL accept a request only in IDLE when exactly one of Rd and Wr is 1 and Addr[1:0]=0, latching Addr, DataIn and op, and moving to COMPARE.
REQ-020 SHALL, in IDLE, pulse err for one cycle when Rd=Wr=1 or when a strobe is present with Addr[1:0]!=0; the state is unchanged, there is no memory activity and Done is not asserted.
REQ-021 SHALL, on a COMPARE hit (valid and tags match), in the same cycle: assert Done=1 and CacheHit=1; for a read drive the stored word on DataOut; for a write update the word and set dirty; then return to IDLE. Hit latency is 1 cycle after acceptance.
REQ-022 SHALL, on a COMPARE miss, go to WRITEBACK if the victim line is valid and dirty, otherwise to FILL.
REQ-023 SHALL, in WRITEBACK, issue WORDS beats at word 0..WORDS-1 with mem_wr=1 and the victim tag/index address; a beat completes on a cycle with mem_ack=1; after the last beat, go to FILL.
REQ-024 SHALL, in FILL, issue WORDS beats with mem_rd=1 at the requested line's address, word 0 first, capturing mem_rdata on mem_ack; after the last beat set valid=1, dirty=0 and the new tag, then go to FINISH.
REQ-025 SHALL hold mem_addr, mem_wdata, mem_rd and mem_wr stable until mem_ack; mem_rd and mem_wr SHALL never both be 1, and both SHALL be 0 outside WRITEBACK and FILL.
REQ-026 SHALL, in FINISH, perform the latched read or write on the now-resident line (a write sets dirty), assert Done=1 with CacheHit=0, and return to IDLE.
REQ-027 SHALL ignore Rd, Wr, Addr and DataIn while Stall=1.
REQ-028 SHALL ignore mem_ack outside WRITEBACK and FILL.
REQ-029 SHALL allow mem_ack to be asserted continuously, giving one beat per cycle, so that a clean miss completes with Done 2+WORDS cycles after acceptance.

Reset
REQ-030 SHALL, while rst=1, clear all valid and dirty bits, force the state to IDLE, and drive Done, Stall, CacheHit, err, mem_rd, mem_wr, DataOut, mem_addr and mem_wdata to 0.
REQ-031 SHALL, when rst is asserted mid-WRITEBACK or mid-FILL, abort the transfer immediately, leave memory contents as written so far, and produce no Done.

Verification
REQ-032 SHALL cover: reset, then Rd at Addr 0x100 with mem_ack always 1 -> FILL reads 0x100, 0x104, 0x108 and 0x10C; Done with CacheHit=0 at cycle 6 after acceptance; DataOut = the word returned at 0x100.
REQ-033 SHALL cover: Rd at Addr 0x104 repeated immediately -> Done=1, CacheHit=1 one cycle after acceptance; no mem_rd activity.
REQ-034 SHALL cover: Wr 0xDEADBEEF at 0x108 (hit), then Rd at 0x1108 (same index, different tag) -> WRITEBACK of 4 words at 0x100..0x10C with 0xDEADBEEF at 0x108; then FILL at 0x1100..0x110C.
REQ-035 SHALL cover: Rd=Wr=1, and separately Rd at Addr 0x102 -> err pulses for one cycle; Stall=0; no Done.
REQ-036 SHALL cover: mem_ack held 0 for 3 cycles per beat -> the memory request outputs stay stable throughout; Done arrives 4*WORDS+2 cycles after acceptance.
REQ-037 SHALL cover: rst asserted during the second FILL beat -> mem_rd=0 immediately; a following Rd to the same address misses.
